// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready handshake on both sides.
// Most opcodes return their result one cycle after acceptance. The result
// is held in HOLD until the consumer takes it.
// Optional feature macro: ALU_PIPE_MUL_EN compiles in a shift-add multiplier
// (opcode 1010) that needs WIDTH cycles in BUSY. Without the macro, 1010 is
// an illegal opcode.

module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUop,
  input  logic             cn,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t             r_state;
  logic               r_outValid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_overflow;
  logic               r_carry;
  logic               r_illegal;

  logic               w_accept;
  logic               w_isMul;
  logic               w_mulLast;
  logic [WIDTH-1:0]   w_mulProduct;
  logic [WIDTH:0]     w_addFull;
  logic [WIDTH:0]     w_subFull;
  logic [WIDTH-1:0]   w_result;
  logic               w_carry;
  logic               w_overflow;
  logic               w_illegal;

  // A new request can enter when idle, or when the held result leaves this cycle.
  assign in_ready  = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_outValid;
  assign r         = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign carry     = r_carry;
  assign illegal   = r_illegal;

  // The extra top bit gives the carry-out for ADD and the borrow-out for SUB.
  assign w_addFull = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cn};
  assign w_subFull = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cn};

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_count;

  assign w_isMul      = (ALUop == OP_MUL);
  assign w_mulLast    = (r_state == BUSY) && (r_count == SHW'(WIDTH - 1));
  assign w_mulProduct = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Shift-add multiplier: consumes one multiplier bit per BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_accept && w_isMul) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == BUSY) begin
      r_acc    <= w_mulProduct;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + SHW'(1);
    end
  end
`else
  assign w_isMul      = 1'b0;
  assign w_mulLast    = 1'b0;
  assign w_mulProduct = '0;
`endif

  // Single-cycle datapath: result and flags for the request at the inputs.
  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    w_illegal  = 1'b0;
    case (ALUop)
      OP_ADD: begin
        w_result   = w_addFull[WIDTH-1:0];
        w_carry    = w_addFull[WIDTH];
        w_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_addFull[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_result   = w_subFull[WIDTH-1:0];
        w_carry    = w_subFull[WIDTH];
        w_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_subFull[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_result = a & b;
      OP_OR:  w_result = a | b;
      OP_XOR: w_result = a ^ b;
      OP_SLL: w_result = a << shamt;
      OP_SRL: w_result = a >> shamt;
      OP_SRA: w_result = $signed(a) >>> shamt;
      OP_SLT: w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        w_result  = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Control FSM. The result and flags register on completion and stay frozen in HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_carry    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_accept && w_isMul) begin
            r_state    <= BUSY;
            r_outValid <= 1'b0;
          end else if (w_accept) begin
            r_state    <= HOLD;
            r_outValid <= 1'b1;
            r_result   <= w_result;
            r_zero     <= (w_result == '0);
            r_overflow <= w_overflow;
            r_carry    <= w_carry;
            r_illegal  <= w_illegal;
          end else if ((r_state == HOLD) && out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
          end
        end
        BUSY: begin
          if (w_mulLast) begin
            r_state    <= HOLD;
            r_outValid <= 1'b1;
            r_result   <= w_mulProduct;
            r_zero     <= (w_mulProduct == '0);
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
            r_illegal  <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe (WIDTH=32).
// Stimulus pushes hand-computed results into a queue. A negedge monitor
// pops and compares them whenever a result handshake happens.

module tb_alu_pipe;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUop;
  logic             cn;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             illegal;

  int checks   = 0;
  int failures = 0;

  // Flags are packed as {zero, overflow, carry, illegal}.
  typedef struct {
    logic [WIDTH-1:0] r;
    logic [3:0]       flags;
    string            name;
  } expItem_t;

  expItem_t expQ[$];

  alu_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .ALUop    (ALUop),
    .cn       (cn),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r        (r),
    .zero     (zero),
    .overflow (overflow),
    .carry    (carry),
    .illegal  (illegal)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request into an idle pipe and confirm its one-cycle latency.
  task automatic applyStimulus(input string name, input logic [3:0] op,
                               input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                               input logic cin, input logic [SHW-1:0] sh,
                               input logic [WIDTH-1:0] expR, input logic [3:0] expFlags);
    @(posedge clk); #1;
    in_valid = 1'b1;
    ALUop    = op;
    a        = opA;
    b        = opB;
    cn       = cin;
    shamt    = sh;
    expQ.push_back('{expR, expFlags, name});
    @(negedge clk);
    checkOutput({name, ".in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    ALUop    = 4'($urandom);
    cn       = 1'($urandom);
    shamt    = SHW'($urandom);
    @(negedge clk);
    checkOutput({name, ".latency"}, out_valid, 1);
  endtask

  // Scoreboard monitor: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got r=0x%0h, expected no output", r);
      end else begin
        expItem_t e;
        e = expQ.pop_front();
        checkOutput({e.name, ".r"}, r, e.r);
        checkOutput({e.name, ".flags"}, {zero, overflow, carry, illegal}, e.flags);
      end
    end
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    ALUop     = '0;
    cn        = 1'b0;
    shamt     = '0;
    #1 reset  = 1'b1;

    @(negedge clk);
    checkOutput("reset.out_valid", out_valid, 0);
    checkOutput("reset.r", r, 0);
    checkOutput("reset.flags", {zero, overflow, carry, illegal}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset.in_ready", in_ready, 1);

    applyStimulus("add_ovf",   4'b0001, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'd0,  32'h8000_0000, 4'b0100);
    applyStimulus("add_wrap",  4'b0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 5'd0,  32'h0000_0000, 4'b1010);
    applyStimulus("sub_eq",    4'b0010, 32'h0000_0005, 32'h0000_0005, 1'b0, 5'd0,  32'h0000_0000, 4'b1000);
    applyStimulus("sub_brw",   4'b0010, 32'h0000_0000, 32'h0000_0001, 1'b0, 5'd0,  32'hFFFF_FFFF, 4'b0010);
    applyStimulus("sub_ovf",   4'b0010, 32'h8000_0000, 32'h0000_0001, 1'b0, 5'd0,  32'h7FFF_FFFF, 4'b0100);
    applyStimulus("sub_bin",   4'b0010, 32'h0000_000A, 32'h0000_0003, 1'b1, 5'd0,  32'h0000_0006, 4'b0000);
    applyStimulus("or",        4'b0100, 32'h1234_0000, 32'h0000_5678, 1'b1, 5'd0,  32'h1234_5678, 4'b0000);
    applyStimulus("sll_max",   4'b0110, 32'h0000_0001, 32'h0000_0000, 1'b0, 5'd31, 32'h8000_0000, 4'b0000);
    applyStimulus("sll_4",     4'b0110, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 5'd4,  32'hFFFF_FFF0, 4'b0000);
    applyStimulus("srl_max",   4'b0111, 32'h8000_0000, 32'h0000_0000, 1'b0, 5'd31, 32'h0000_0001, 4'b0000);
    applyStimulus("sra_max",   4'b1000, 32'h8000_0000, 32'h0000_0000, 1'b0, 5'd31, 32'hFFFF_FFFF, 4'b0000);
    applyStimulus("sra_pos",   4'b1000, 32'h4000_0000, 32'h0000_0000, 1'b0, 5'd4,  32'h0400_0000, 4'b0000);
    applyStimulus("slt_neg",   4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd0,  32'h0000_0001, 4'b0000);
    applyStimulus("slt_pos",   4'b1001, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0000_0000, 4'b1000);
    applyStimulus("slt_eq",    4'b1001, 32'h0000_0005, 32'h0000_0005, 1'b0, 5'd0,  32'h0000_0000, 4'b1000);
    applyStimulus("ill_f",     4'b1111, 32'h0000_1234, 32'h0000_5678, 1'b0, 5'd0,  32'h0000_0000, 4'b1001);
    applyStimulus("ill_0",     4'b0000, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 5'd3,  32'h0000_0000, 4'b1001);
`ifndef ALU_PIPE_MUL_EN
    applyStimulus("ill_mul",   4'b1010, 32'h0000_0003, 32'h0000_0004, 1'b0, 5'd0,  32'h0000_0000, 4'b1001);
`endif

    // Backpressure: AND result held for five cycles while the inputs wander.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ALUop     = 4'b0011;
    a         = 32'h0000_F0F0;
    b         = 32'h0000_FF00;
    cn        = 1'b1;
    expQ.push_back('{32'h0000_F000, 4'b0000, "bp_and"});
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp.hold%0d.valid", i), out_valid, 1);
      checkOutput($sformatf("bp.hold%0d.r", i), r, 32'h0000_F000);
      checkOutput($sformatf("bp.hold%0d.in_ready", i), in_ready, 0);
      @(posedge clk); #1;
      a     = $urandom;
      b     = $urandom;
      ALUop = 4'($urandom);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ALUop     = 4'b0101;
    a         = 32'h0000_0001;
    b         = 32'h0000_0001;
    cn        = 1'b0;
    expQ.push_back('{32'h0000_0000, 4'b1000, "bp_xor"});
    @(negedge clk);
    checkOutput("bp.b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp.b2b_latency", out_valid, 1);

    // Reset while a result is being held must clear everything at once.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ALUop     = 4'b0001;
    a         = 32'h7FFF_FFFF;
    b         = 32'h0000_0001;
    cn        = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_hold.pre_valid", out_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_hold.valid", out_valid, 0);
    checkOutput("rst_hold.r", r, 0);
    checkOutput("rst_hold.flags", {zero, overflow, carry, illegal}, 0);
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_hold.in_ready", in_ready, 1);
    checkOutput("rst_hold.post_valid", out_valid, 0);

`ifdef ALU_PIPE_MUL_EN
    // Iterative multiply: busy for WIDTH cycles, result on cycle WIDTH+1.
    @(posedge clk); #1;
    in_valid = 1'b1;
    ALUop    = 4'b1010;
    a        = 32'h0001_0000;
    b        = 32'h0001_0003;
    cn       = 1'b0;
    expQ.push_back('{32'h0003_0000, 4'b0000, "mul"});
    @(negedge clk);
    checkOutput("mul.in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mul.busy%0d", i), {out_valid, in_ready}, 0);
      @(posedge clk); #1;
      a     = $urandom;
      b     = $urandom;
      ALUop = 4'($urandom);
    end
    @(negedge clk);
    checkOutput("mul.latency", out_valid, 1);

    // Reset ten cycles into a multiply discards it.
    @(posedge clk); #1;
    in_valid = 1'b1;
    ALUop    = 4'b1010;
    a        = 32'h0001_0000;
    b        = 32'h0001_0003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mul_rst.valid", out_valid, 0);
    checkOutput("mul_rst.r", r, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mul_rst.in_ready", in_ready, 1);
    repeat (WIDTH + 4) @(negedge clk);
    checkOutput("mul_rst.no_result", out_valid, 0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("queue_drain", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001: Parameter WIDTH, default 32, SHALL set the operand and result width; legal values are 8, 16, 32 or 64.
REQ-002: Parameter SHW, default 5, SHALL set the shift-amount width and SHALL equal log2(WIDTH).
REQ-003: clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004: reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005: in_valid  input  1  SHALL mark a valid operation request.
REQ-006: in_ready  output  1  SHALL indicate that a request is accepted this cycle.
REQ-007: a, b  input  WIDTH each  SHALL carry the operands.
REQ-008: ALUop  input  4  SHALL carry the opcode.
REQ-009: cn  input  1  SHALL carry the carry-in for ADD and the borrow-in for SUB.
REQ-010: shamt  input  SHW  SHALL carry the shift amount.
REQ-011: out_valid  output  1  SHALL mark a valid result.
REQ-012: out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-013: r  output  WIDTH  SHALL carry the result.
REQ-014: zero, overflow, carry, illegal  output  1 each  SHALL carry the result flags.

Function
REQ-015: The opcodes SHALL be as follows.
- 0001 ADD: a+b+cn
- 0010 SUB: a-b-cn
- 0011 AND
- 0100 OR
- 0101 XOR
- 0110 SLL: a<<shamt
- 0111 SRL: logical a>>shamt
- 1000 SRA: arithmetic a>>>shamt
- 1001 SLT: signed a<b gives 1, else 0
- 1010 MUL: low WIDTH bits of unsigned a*b
REQ-016: The FSM SHALL have the states IDLE, BUSY and HOLD.
- in_ready=1 only in IDLE, and in HOLD when out_ready=1.
REQ-017: A request accepted on cycle N with a non-MUL opcode SHALL produce out_valid=1 with its result on cycle N+1, and the FSM SHALL move to HOLD.
REQ-018: An accepted MUL SHALL enter BUSY and iterate shift-add for exactly WIDTH cycles, then go to HOLD.
- out_valid is asserted WIDTH+1 cycles after acceptance.
- in_ready=0 throughout BUSY.
REQ-019: In HOLD, r and the flags SHALL stay stable while out_ready=0.
REQ-020: In HOLD with out_ready=1 and in_valid=1, the result SHALL be consumed and the new request accepted in the same cycle, giving back-to-back single-cycle throughput.
REQ-021: In HOLD with out_ready=1 and in_valid=0, the FSM SHALL return to IDLE, with out_valid=0 on the next cycle.
REQ-022: zero SHALL be 1 when r==0.
REQ-023: carry SHALL be the carry-out for ADD and the borrow-out for SUB, and 0 for all other opcodes.
REQ-024: overflow SHALL be signed two's-complement overflow for ADD and SUB, and 0 for all other opcodes.
REQ-025: Opcodes 0000 and 1011-1111 SHALL complete in 1 cycle with r=0, zero=1 and illegal=1; every legal opcode SHALL give illegal=0.
REQ-026: All arithmetic SHALL be modulo 2^WIDTH.
- A shamt of WIDTH-1 is legal.
- SRA fills with a[WIDTH-1].
REQ-027: Operands and opcode SHALL be captured at acceptance; input changes during BUSY or HOLD SHALL have no effect.

Reset
REQ-028: Asserting reset SHALL immediately force the following, including mid-MUL, with the partial product discarded:
- FSM=IDLE, out_valid=0, r=0
- zero=0, overflow=0, carry=0, illegal=0
REQ-029: After reset deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-030: With macro ALU_PIPE_MUL_EN defined, the iterative multiplier and the BUSY state SHALL be compiled in and MUL SHALL behave as in REQ-018.
REQ-031: Without ALU_PIPE_MUL_EN, opcode 1010 SHALL be treated as illegal per REQ-025, and BUSY SHALL be unreachable.

Verification
REQ-032: ADD, WIDTH=32: a=0x7FFFFFFF, b=1, cn=0 -> next cycle r=0x80000000, overflow=1, carry=0, zero=0.
REQ-033: SUB: a=5, b=5, cn=0 -> r=0, zero=1, carry=0; then a=0, b=1 -> r=0xFFFFFFFF, carry=1.
REQ-034: SRA: a=0x80000000, shamt=31 -> r=0xFFFFFFFF; SRL with the same inputs -> r=1.
REQ-035: MUL with ALU_PIPE_MUL_EN: a=0x10000, b=0x10003 -> out_valid after 33 cycles, r=0x00030000; in_ready=0 throughout; reset asserted at cycle 10 -> out_valid=0 and in_ready=1 after release.
REQ-036: Backpressure: out_ready held 0 for 5 cycles after an AND of 0xF0F0 and 0xFF00 -> r stays 0xF000 and in_ready=0; then out_ready=1 with in_valid=1 (XOR 1,1) -> next cycle r=0, zero=1.
REQ-037: ALUop=1111 -> r=0, illegal=1; without ALU_PIPE_MUL_EN, ALUop=1010 -> illegal=1 with 1-cycle latency.
